// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: configuration handshake carrying terminal count and reload mode
interface counter_sequencer_if #(parameter int WIDTH = 3);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_reload;
    modport master (output cfg_valid, cfg_limit, cfg_reload, input cfg_ready);
    modport slave  (input cfg_valid, cfg_limit, cfg_reload, output cfg_ready);
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: configurable up-counter with one-shot/auto-reload, pause and abort control
module counter_sequencer #(parameter int WIDTH = 3) (
    input  logic               CLK,
    input  logic               RST,
    counter_sequencer_if.slave cfg,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   Q,
    output logic               busy,
    output logic               tc,
    output logic               done
);
    typedef enum logic [2:0] {IDLE, ARMED, RUN, HOLD, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, limit_q, limit_d;
    logic             reload_q, reload_d, hs;

    assign hs = cfg.cfg_valid & cfg.cfg_ready;
    assign Q  = q_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            q_q      <= '0;
            limit_q  <= '0;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
        end
    end

    // Handshake latching is independent of the state transition, so an ARMED start sees the new values.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        limit_d  = hs ? cfg.cfg_limit : limit_q;
        reload_d = hs ? cfg.cfg_reload : reload_q;
        if (abort && state_q != IDLE) begin
            state_d = ARMED;
            q_d     = '0;
        end else begin
            case (state_q)
                IDLE:  if (hs) state_d = ARMED;
                ARMED: if (start) begin
                    state_d = RUN;
                    q_d     = '0;
                end
                RUN: begin
                    if (pause) state_d = HOLD;
                    else if (q_q == limit_q) begin
                        if (reload_q) q_d = '0;
                        else state_d = DONE;
                    end else q_d = q_q + WIDTH'(1);
                end
                HOLD:    if (!pause) state_d = RUN;
                DONE:    state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg.cfg_ready = state_q == IDLE || state_q == ARMED;
        busy          = state_q == RUN || state_q == HOLD;
        tc            = state_q == RUN && q_q == limit_q;
        done          = state_q == DONE;
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: random and directed stimulus scored against a behavioural model via a queue
module tb_counter_sequencer;
    localparam int W = 3;
    logic         CLK = 1'b0;
    logic         RST, start, pause, abort;
    logic [W-1:0] Q;
    logic         busy, tc, done;

    counter_sequencer_if #(.WIDTH(W)) cif();

    counter_sequencer #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .cfg(cif.slave), .start(start), .pause(pause),
        .abort(abort), .Q(Q), .busy(busy), .tc(tc), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] q;
        logic         ready, busy, tc, done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    // Model: configured flag plus running/paused/finishing flags and an integer count.
    int m_q = 0, m_lim = 0;
    bit m_rel = 0, cfgd = 0, running = 0, paused = 0, finishing = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit v, input int lim, input bit rel, input bit st,
                       input bit pa, input bit ab, input bit rs);
        bit   accept;
        exp_t e;
        @(negedge CLK);
        cif.cfg_valid  = v;
        cif.cfg_limit  = W'(lim);
        cif.cfg_reload = rel;
        start = st; pause = pa; abort = ab; RST = rs;
        if (rs) begin
            m_q = 0; m_lim = 0; m_rel = 0;
            cfgd = 0; running = 0; paused = 0; finishing = 0;
        end else begin
            accept = v && !(running || paused || finishing);
            if (ab && cfgd) begin
                running = 0; paused = 0; finishing = 0; m_q = 0;
            end else if (finishing) finishing = 0;
            else if (paused) begin
                if (!pa) begin paused = 0; running = 1; end
            end else if (running) begin
                if (pa) begin running = 0; paused = 1; end
                else if (m_q == m_lim) begin
                    if (m_rel) m_q = 0;
                    else begin running = 0; finishing = 1; end
                end else m_q++;
            end else if (cfgd && st) begin
                running = 1; m_q = 0;
            end
            if (accept) begin
                m_lim = lim; m_rel = rel; cfgd = 1;
                if (st && !running && m_q == 0) begin
                end
            end
        end
        e.q     = W'(m_q);
        e.ready = !(running || paused || finishing);
        e.busy  = running || paused;
        e.tc    = running && m_q == m_lim;
        e.done  = finishing;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input int lim, input bit rel);
        cyc(1, lim, rel, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("Q", 32'(Q), 32'(e.q));
                check("cfg_ready", 32'(cif.cfg_ready), 32'(e.ready));
                check("busy", 32'(busy), 32'(e.busy));
                check("tc", 32'(tc), 32'(e.tc));
                check("done", 32'(done), 32'(e.done));
            end
        end
    end

    initial begin : stim
        int t;
        RST = 1; start = 0; pause = 0; abort = 0;
        cif.cfg_valid = 0; cif.cfg_limit = '0; cif.cfg_reload = 0;
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1, 0);
        idle(2);
        go(2, 0); idle(6);
        go(3, 1); idle(10); cyc(0, 0, 0, 0, 0, 1, 0);
        go(5, 0); idle(2);
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
        idle(8);
        go(7, 0); idle(4); cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0); idle(3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0); idle(2);
        go(0, 0); idle(3);
        go(0, 1); idle(3); cyc(0, 0, 0, 0, 1, 0, 0); idle(2);
        cyc(0, 0, 0, 0, 0, 1, 0);
        go(7, 1); idle(4); cyc(1, 2, 0, 0, 0, 0, 0); idle(10);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 4, 0, 1, 0, 0, 0); idle(7);
        repeat (1500)
            cyc($urandom_range(3) == 0, $urandom_range(7), $urandom_range(1),
                $urandom_range(2) == 0, $urandom_range(5) == 0,
                $urandom_range(19) == 0, $urandom_range(63) == 0);
        idle(2);
        @(posedge CLK);
        #2;
        t = 0;
        while (sb.size() > 0 && t < 20) begin
            @(posedge CLK);
            #2;
            t++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL provide parameter: WIDTH, default 3, counter and limit width in bits (legal range 1..16).
REQ-002 SHALL provide port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: cfg_valid  input  1  configuration offer.
REQ-005 SHALL provide port: cfg_ready  output  1  configuration accept; high in IDLE and ARMED only.
REQ-006 SHALL provide port: cfg_limit  input  WIDTH  terminal count value.
REQ-007 SHALL provide port: cfg_reload  input  1  1 = auto-reload mode, 0 = one-shot mode.
REQ-008 SHALL provide port: start  input  1  level-sampled run request.
REQ-009 SHALL provide port: pause  input  1  freeze request while running.
REQ-010 SHALL provide port: abort  input  1  cancel current run.
REQ-011 SHALL provide port: Q  output  WIDTH  registered count value.
REQ-012 SHALL provide port: busy  output  1  high in RUN or HOLD.
REQ-013 SHALL provide port: tc  output  1  terminal count: high when state = RUN and Q = latched limit.
REQ-014 SHALL provide port: done  output  1  high exactly during the single DONE-state cycle.

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, RUN, HOLD, DONE; cfg_ready, busy, tc and done decoded from state and registers only, with no combinational path from any input.
REQ-016 SHALL latch cfg_limit and cfg_reload into internal registers on any edge where cfg_valid and cfg_ready are both 1; IDLE -> ARMED on that edge.
REQ-017 SHALL ignore start in IDLE (no configuration yet), RUN, HOLD and DONE.
REQ-018 SHALL, in ARMED with start = 1, go to RUN and load Q = 0; if a handshake completes on the same edge, the run uses the newly latched values.
REQ-019 SHALL, in RUN with pause = 0 and Q != limit, increment Q by 1 per cycle.
REQ-020 SHALL, in RUN with pause = 0 and Q = limit: if reload = 1, set Q = 0 and stay in RUN; if reload = 0, hold Q and go to DONE.
REQ-021 SHALL, in RUN with pause = 1, go to HOLD without changing Q, even when Q = limit.
REQ-022 SHALL hold Q in HOLD and return to RUN on the first edge with pause = 0; no increment occurs on that edge.
REQ-023 SHALL go from DONE to ARMED unconditionally after one cycle, retaining the latched configuration and leaving Q unchanged.
REQ-024 SHALL, on abort = 1 in ARMED, RUN, HOLD or DONE, go to ARMED with Q = 0; done is not asserted and configuration is retained; abort is ignored in IDLE.
REQ-025 SHALL apply input priority RST > abort > pause > start/terminal logic.
REQ-026 SHALL treat limit = 0 as a valid setting: tc is high in the first RUN cycle; one-shot then goes to DONE, and reload keeps Q = 0 with tc high every non-paused RUN cycle.
REQ-027 SHALL treat limit = 2^WIDTH-1 as valid: Q reaches all-ones and never exceeds the limit.
REQ-028 SHALL allow no arithmetic wrap other than the reload to 0 in REQ-020.

Reset
REQ-029 SHALL, on a rising edge with RST = 1 in any state (including mid-run), set state = IDLE, Q = 0, latched limit = 0 and latched reload = 0.
REQ-030 SHALL output cfg_ready = 1, busy = 0, tc = 0 and done = 0 in the cycle following reset; a configuration is required again before any run.

Verification
REQ-031 SHALL verify one-shot: WIDTH = 3, cfg limit = 2, reload = 0, start pulse -> Q = 0,1,2 on successive cycles; tc high with Q = 2; next cycle done = 1 with Q = 2; next cycle ARMED, done = 0.
REQ-032 SHALL verify reload: limit = 3, reload = 1 -> Q = 0,1,2,3,0,1...; tc high on each Q = 3 cycle; done never asserts; busy held high.
REQ-033 SHALL verify pause: one-shot limit = 5, pause high for 3 cycles while Q = 2 -> Q holds 2 for 4 cycles (3 HOLD cycles plus the resume edge), then continues to 3; busy stays high throughout.
REQ-034 SHALL verify abort and reset: abort at Q = 4 -> next cycle ARMED, Q = 0, done = 0; start restarts from 0; RST at Q = 3 -> IDLE, Q = 0, and start is ignored until a new handshake.
REQ-035 SHALL verify boundaries: limit = 0 one-shot -> tc for one cycle, then done; limit = 7 reload -> Q reaches 7, then 0; cfg_valid asserted in RUN -> not accepted, latched limit unchanged.
